// File: rtl/pulse_burst_sched.sv
// pulse_burst_sched: round-robin owner of a shared divide-by-10 pulse counter.
// Each requester asks for a burst of N counter pulses. The winner gets the
// counter cleared, enabled, and its pulses routed back until N have been seen,
// and then receives a one-cycle done pulse.
//
// Handshake: a requester raises req[i] with req_len[i] valid and holds req[i]
// high until it sees done[i]. Dropping req[i] before that while granted aborts
// the burst with no done. gnt[i] marks ownership from the cycle after req is
// sampled until the cycle after done (or after an abort).
module pulse_burst_sched #(
   parameter int NREQ  = 4,
   parameter int LEN_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*LEN_W-1:0] req_len,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic                  busy,
   output logic [NREQ-1:0]       pulse_out,
   output logic                  cnt_clr,
   output logic                  cnt_start,
   input  logic                  cnt_pulse
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

   state_t           state, next_state;
   logic [IDX_W-1:0] ptr, idx, sel_idx, idx_nxt;
   logic             sel_vld;
   logic [LEN_W-1:0] len_q, pcnt, pcnt_inc, sel_len;
   logic             abort, hit;

   // Round-robin pick: first requester at or above the pointer, wrapping.
   always_comb begin
      sel_idx = '0;
      sel_vld = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!sel_vld && req[(int'(ptr) + k) % NREQ]) begin
            sel_vld = 1'b1;
            sel_idx = IDX_W'((int'(ptr) + k) % NREQ);
         end
      end
   end

   assign sel_len  = req_len[sel_idx*LEN_W +: LEN_W];
   assign idx_nxt  = (idx == IDX_W'(NREQ - 1)) ? '0 : idx + IDX_W'(1);
   assign abort    = ~req[idx];
   assign pcnt_inc = pcnt + LEN_W'(1);
   assign hit      = (pcnt_inc == len_q);

   // Route counter pulses to the owner only while running and not aborting.
   always_comb begin
      pulse_out = '0;
      if (state == RUN && cnt_pulse && !abort) begin
         pulse_out = gnt;
      end
   end

   // Next-state logic; abort takes precedence over burst completion.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (sel_vld) begin
               next_state = (sel_len == '0) ? DONE : CLEAR;
            end
         end
         CLEAR: begin
            next_state = abort ? IDLE : RUN;
         end
         RUN: begin
            if (abort) begin
               next_state = IDLE;
            end else if (cnt_pulse && hit) begin
               next_state = DONE;
            end
         end
         DONE: begin
            // Stay until done has actually been issued; a zero-length grant
            // arrives here without it and spends one extra cycle.
            next_state = (|done) ? IDLE : DONE;
         end
         default: next_state = IDLE;
      endcase
   end

   // State register, grant bookkeeping and registered counter controls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         gnt       <= '0;
         done      <= '0;
         busy      <= 1'b0;
         cnt_clr   <= 1'b0;
         cnt_start <= 1'b0;
         ptr       <= '0;
         idx       <= '0;
         len_q     <= '0;
         pcnt      <= '0;
      end else begin
         state     <= next_state;
         busy      <= (next_state != IDLE);
         cnt_clr   <= (next_state == CLEAR);
         cnt_start <= (next_state == RUN);
         done      <= '0;
         case (state)
            IDLE: begin
               if (sel_vld) begin
                  idx   <= sel_idx;
                  len_q <= sel_len;
                  gnt   <= NREQ'(1) << sel_idx;
               end
            end
            CLEAR: begin
               pcnt <= '0;
               if (abort) begin
                  gnt <= '0;
                  ptr <= idx_nxt;
               end
            end
            RUN: begin
               if (abort) begin
                  gnt <= '0;
                  ptr <= idx_nxt;
               end else if (cnt_pulse) begin
                  pcnt <= pcnt_inc;
                  if (hit) begin
                     done <= gnt;
                  end
               end
            end
            DONE: begin
               if (|done) begin
                  gnt <= '0;
                  ptr <= idx_nxt;
               end else begin
                  done <= gnt;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_burst_sched.sv
// Bench for pulse_burst_sched: drives bursts through a divide-by-10 counter
// model, checks grant order, pulse routing, done timing, abort and reset.
module tb_pulse_burst_sched;

   localparam int NREQ  = 4;
   localparam int LEN_W = 8;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*LEN_W-1:0] req_len = '0;
   logic [NREQ-1:0]       gnt, done, pulse_out;
   logic                  busy, cnt_clr, cnt_start, cnt_pulse;
   logic                  extra_pulse = 1'b0;
   logic [3:0]            mcnt;
   logic                  mpulse;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0]  req;
      logic [31:0] lens;
      logic [31:0] lens_chg;
      logic        chg;
      logic        inj;
      logic [3:0]  exp_gnt;
      int          exp_done;
      int          exp_pulses;
   } vec_t;

   vec_t vecs[9];

   pulse_burst_sched #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .req_len   (req_len),
      .gnt       (gnt),
      .done      (done),
      .busy      (busy),
      .pulse_out (pulse_out),
      .cnt_clr   (cnt_clr),
      .cnt_start (cnt_start),
      .cnt_pulse (cnt_pulse)
   );

   // Clock
   always #5 clk = ~clk;

   // Divide-by-10 counter model: first pulse in the 11th enabled cycle after a clear.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mcnt   <= '0;
         mpulse <= 1'b0;
      end else if (cnt_clr) begin
         mcnt   <= '0;
         mpulse <= 1'b0;
      end else if (cnt_start) begin
         mcnt   <= (mcnt == 4'd9) ? 4'd0 : mcnt + 4'd1;
         mpulse <= (mcnt == 4'd9);
      end else begin
         mpulse <= 1'b0;
      end
   end

   assign cnt_pulse = mpulse | extra_pulse;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      req_len = '0;
      extra_pulse = 1'b0;
      repeat (2) tick();
      rst = 1'b0;
      tick();
   endtask

   task automatic wait_gnt(output int lat);
      lat = 0;
      while (gnt == '0 && lat < 10) begin
         tick();
         lat++;
      end
   endtask

   task automatic run_burst(input vec_t v);
      int         lat, offs, pulses, done_at;
      logic [3:0] misroute, done_val;
      logic       start_seen;
      req = v.req;
      req_len = v.lens;
      wait_gnt(lat);
      chk("arb_latency", lat, 1);
      chk("gnt", gnt, v.exp_gnt);
      chk("cnt_clr_at_gnt", cnt_clr, v.exp_pulses != 0);
      chk("busy_at_gnt", busy, 1);
      chk("cnt_start_at_gnt", cnt_start, 0);
      offs = 0;
      pulses = 0;
      done_at = -1;
      done_val = '0;
      misroute = '0;
      start_seen = 1'b0;
      while (offs <= v.exp_done + 20) begin
         extra_pulse = v.inj && (offs == 0);
         if (v.chg && offs == 3) req_len = v.lens_chg;
         #1;
         pulses += $countones(pulse_out & v.exp_gnt);
         misroute |= pulse_out & ~gnt;
         start_seen |= cnt_start;
         if (done != '0) begin
            done_at = offs;
            done_val = done;
            break;
         end
         tick();
         offs++;
      end
      extra_pulse = 1'b0;
      chk("done_offset", done_at, v.exp_done);
      chk("done_value", done_val, v.exp_gnt);
      chk("pulse_count", pulses, v.exp_pulses);
      chk("pulse_misroute", misroute, 0);
      if (v.exp_pulses == 0) chk("zero_len_no_start", start_seen, 0);
      req = '0;
      tick();
      chk("gnt_after_done", gnt, 0);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
   endtask

   initial begin
      int lat, seen, done_any;

      // Vectors from reset (pointer 0); pointer after each is noted.
      vecs[0] = '{4'b0001, 32'h00000003, 32'h0, 1'b0, 1'b0, 4'b0001, 32, 3}; // ptr 1
      vecs[1] = '{4'b1111, 32'h01010101, 32'h0, 1'b0, 1'b0, 4'b0010, 12, 1}; // ptr 2
      vecs[2] = '{4'b0101, 32'h00000002, 32'h0, 1'b0, 1'b0, 4'b0100, 1,  0}; // ptr 3
      vecs[3] = '{4'b0011, 32'h00000201, 32'h0, 1'b0, 1'b1, 4'b0001, 12, 1}; // ptr 1
      vecs[4] = '{4'b1001, 32'h02000001, 32'h0, 1'b0, 1'b0, 4'b1000, 22, 2}; // ptr 0
      vecs[5] = '{4'b0001, 32'h00000002, 32'h00000007, 1'b1, 1'b0, 4'b0001, 22, 2}; // ptr 1
      vecs[6] = '{4'b0110, 32'h00010400, 32'h0, 1'b0, 1'b0, 4'b0010, 42, 4}; // ptr 2
      vecs[7] = '{4'b1110, 32'h01000100, 32'h0, 1'b0, 1'b0, 4'b0100, 1,  0}; // ptr 3
      vecs[8] = '{4'b1110, 32'h01000100, 32'h0, 1'b0, 1'b0, 4'b1000, 12, 1}; // ptr 0

      // Reset state
      do_reset();
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt_clr", cnt_clr, 0);
      chk("rst_cnt_start", cnt_start, 0);
      chk("rst_pulse_out", pulse_out, 0);

      for (int i = 0; i < 9; i++) run_burst(vecs[i]);

      // Round-robin with all four held: grants 0,1,2,3,0, 14 cycles apart.
      do_reset();
      begin
         logic [3:0] order [5];
         int         rise_t [5];
         int         t;
         order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
         req = 4'b1111;
         req_len = 32'h01010101;
         t = 0;
         for (int g = 0; g < 5; g++) begin
            lat = 0;
            while (gnt == '0 && lat < 20) begin
               tick();
               t++;
               lat++;
            end
            rise_t[g] = t;
            chk("rr_order", gnt, order[g]);
            lat = 0;
            while (done == '0 && lat < 20) begin
               tick();
               t++;
               lat++;
            end
            chk("rr_done_onehot", done, order[g]);
            chk("rr_done_offset", t - rise_t[g], 12);
            tick();
            t++;
            chk("rr_gnt_drop", gnt, 0);
            if (g > 0) chk("rr_period", rise_t[g] - rise_t[g-1], 14);
         end
         req = '0;
         tick();
      end

      // Abort: req[1] len 5 dropped just before its third pulse.
      do_reset();
      req = 4'b0010;
      req_len = 32'h00000500;
      wait_gnt(lat);
      chk("abort_gnt", gnt, 4'b0010);
      seen = 0;
      lat = 0;
      while (seen < 2 && lat < 40) begin
         tick();
         lat++;
         seen += $countones(pulse_out);
      end
      chk("abort_two_pulses", seen, 2);
      repeat (9) tick();
      req = '0;
      tick();
      chk("abort_pulse_blocked", pulse_out, 0);
      chk("abort_no_done", done, 0);
      tick();
      chk("abort_gnt_clear", gnt, 0);
      chk("abort_start_clear", cnt_start, 0);
      chk("abort_busy_clear", busy, 0);
      done_any = 0;
      repeat (5) begin
         tick();
         done_any |= int'(|done);
      end
      chk("abort_no_late_done", done_any, 0);
      run_burst('{4'b0110, 32'h00010100, 32'h0, 1'b0, 1'b0, 4'b0100, 12, 1});

      // Reset in the middle of a run, then a fresh grant for requester 3.
      do_reset();
      req = 4'b1000;
      req_len = 32'h03000000;
      wait_gnt(lat);
      chk("midrst_gnt", gnt, 4'b1000);
      repeat (5) tick();
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_gnt_zero", gnt, 0);
      chk("midrst_busy_zero", busy, 0);
      chk("midrst_start_zero", cnt_start, 0);
      chk("midrst_done_zero", done, 0);
      tick();
      rst = 1'b0;
      run_burst('{4'b1000, 32'h02000000, 32'h0, 1'b0, 1'b0, 4'b1000, 22, 2});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
